// File: rtl/ctrl_seq.sv
// ctrl_seq: Moore instruction sequencer for the Prathama core.
// Owns the PC and walks fetch/decode/execute/memory handshakes.
module ctrl_seq #(
  parameter int IR_W    = 32,
  parameter int ADDR_W  = 16,
  parameter int N_EU    = 2,
  parameter int PC_STEP = 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = (N_EU > 1) ? $clog2(N_EU) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  output logic              fetch_cs,
  input  logic              fetch_ready,
  input  logic [IR_W-1:0]   fetch_ir,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [IR_W-1:0]   ir,
  output logic              dec_cs,
  input  logic              dec_ready,
  input  logic [SEL_W-1:0]  dec_eu_sel,
  input  logic              dec_mem,
  input  logic              dec_branch,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic              dec_halt,
  output logic [N_EU-1:0]   eu_cs,
  input  logic [N_EU-1:0]   eu_ready,
  output logic              biu_cs,
  input  logic              biu_ready,
  output logic [2:0]        state,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CNT_W-1:0]  retired
);

  localparam int WT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DEC    = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_COMMIT = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              mem_q, mem_d;
  logic              br_q, br_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [WT_W-1:0]   wait_q, wait_d;
  logic [1:0]        code_q, code_d;

  logic [N_EU-1:0]   eu_oh;
  logic              waiting;
  logic              rdy;
  logic              bad_sel;

  assign eu_oh   = N_EU'(1) << sel_q;
  assign bad_sel = {{(32-SEL_W){1'b0}}, dec_eu_sel} >= 32'(N_EU);

  // Next-state, datapath latches and handshake timeout.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    sel_d   = sel_q;
    mem_d   = mem_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    code_d  = code_q;
    wait_d  = '0;
    waiting = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        waiting = 1'b1;
        rdy     = fetch_ready;
        if (fetch_ready) begin
          ir_d    = fetch_ir;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        waiting = 1'b1;
        rdy     = dec_ready;
        if (dec_ready) begin
          sel_d = dec_eu_sel;
          mem_d = dec_mem;
          br_d  = dec_branch;
          tgt_d = dec_target;
          if (dec_halt) begin
            state_d = S_HALT;
          end else if (bad_sel) begin
            state_d = S_FAULT;
            code_d  = 2'd2;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        waiting = 1'b1;
        rdy     = |(eu_ready & eu_oh);
        if (rdy) state_d = mem_q ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        waiting = 1'b1;
        rdy     = biu_ready;
        if (biu_ready) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        pc_d    = br_q ? tgt_q : pc_q + ADDR_W'(PC_STEP);
        ret_d   = ret_q + CNT_W'(1);
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Ready on the final allowed edge beats the timeout.
    if (waiting && !rdy) begin
      if (wait_q == WT_W'(TIMEOUT - 1)) begin
        state_d = S_FAULT;
        code_d  = 2'd1;
      end else begin
        wait_d = wait_q + WT_W'(1);
      end
    end
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
      sel_q   <= '0;
      mem_q   <= 1'b0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
      wait_q  <= '0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      sel_q   <= sel_d;
      mem_q   <= mem_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
      wait_q  <= wait_d;
      code_q  <= code_d;
    end
  end

  assign fetch_cs   = (state_q == S_FETCH);
  assign dec_cs     = (state_q == S_DEC);
  assign eu_cs      = (state_q == S_EXEC) ? eu_oh : '0;
  assign biu_cs     = (state_q == S_MEM);
  assign state      = state_q;
  assign busy       = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
  assign fault      = (state_q == S_FAULT);
  assign fault_code = code_q;
  assign fetch_addr = pc_q;
  assign ir         = ir_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq.
// Commit results are queued at COMMIT and checked one cycle later.
module tb_ctrl_seq;

  localparam int IR_W = 32;
  localparam int ADDR_W = 16;
  localparam int N_EU = 3;
  localparam int CNT_W = 16;
  localparam int TMO = 15;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DEC    = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;
  localparam logic [2:0] FAULT  = 3'd7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              halt_req;
  logic              fetch_cs;
  logic              fetch_ready;
  logic [IR_W-1:0]   fetch_ir;
  logic [ADDR_W-1:0] fetch_addr;
  logic [IR_W-1:0]   ir;
  logic              dec_cs;
  logic              dec_ready;
  logic [1:0]        dec_eu_sel;
  logic              dec_mem;
  logic              dec_branch;
  logic [ADDR_W-1:0] dec_target;
  logic              dec_halt;
  logic [N_EU-1:0]   eu_cs;
  logic [N_EU-1:0]   eu_ready;
  logic              biu_cs;
  logic              biu_ready;
  logic [2:0]        state;
  logic              busy;
  logic              fault;
  logic [1:0]        fault_code;
  logic [CNT_W-1:0]  retired;

  always #5 clk = ~clk;

  ctrl_seq #(
    .IR_W(IR_W), .ADDR_W(ADDR_W), .N_EU(N_EU),
    .PC_STEP(1), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .halt_req(halt_req), .fetch_cs(fetch_cs),
    .fetch_ready(fetch_ready), .fetch_ir(fetch_ir),
    .fetch_addr(fetch_addr), .ir(ir), .dec_cs(dec_cs),
    .dec_ready(dec_ready), .dec_eu_sel(dec_eu_sel),
    .dec_mem(dec_mem), .dec_branch(dec_branch),
    .dec_target(dec_target), .dec_halt(dec_halt),
    .eu_cs(eu_cs), .eu_ready(eu_ready), .biu_cs(biu_cs),
    .biu_ready(biu_ready), .state(state), .busy(busy),
    .fault(fault), .fault_code(fault_code),
    .retired(retired)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ret;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  logic        was_commit = 1'b0;

  // Pop one expectation on the cycle after each COMMIT.
  always @(negedge clk) begin
    if (was_commit) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        chk("sb_pc", fetch_addr, sb_q[0].pc);
        chk("sb_retired", retired, sb_q[0].ret);
        chk("sb_state", state, sb_q[0].st);
        void'(sb_q.pop_front());
      end
    end
    was_commit <= (state == COMMIT) && reset;
  end

  task automatic clr_in();
    fetch_ready = 1'b0;
    fetch_ir    = '0;
    dec_ready   = 1'b0;
    dec_eu_sel  = '0;
    dec_mem     = 1'b0;
    dec_branch  = 1'b0;
    dec_target  = '0;
    dec_halt    = 1'b0;
    eu_ready    = '0;
    biu_ready   = 1'b0;
  endtask

  // One instruction starting in FETCH; fd fetch stalls,
  // ew cycles of wrong-EU ready during EXEC.
  task automatic do_instr(input int fd, input int ew,
                          input logic [1:0] sel,
                          input bit mem, input bit br,
                          input bit hlt,
                          input logic [15:0] tgt,
                          output int cyc);
    logic [31:0] w;
    logic [2:0]  oh;
    w   = $urandom;
    oh  = 3'b001 << sel;
    cyc = 0;
    chk("in_fetch", state, FETCH);
    chk("fetch_cs", fetch_cs, 1);
    chk("pc_fetch", fetch_addr, m_pc);
    fetch_ir = w;
    repeat (fd) begin
      @(negedge clk);
      cyc++;
    end
    chk("fetch_wait", state, FETCH);
    chk("pc_stable", fetch_addr, m_pc);
    fetch_ready = 1'b1;
    @(negedge clk);
    cyc++;
    clr_in();
    chk("ir", ir, w);
    chk("in_dec", state, DEC);
    chk("fetch_cs_off", fetch_cs, 0);
    chk("dec_cs", dec_cs, 1);
    dec_eu_sel = sel;
    dec_mem    = mem;
    dec_branch = br;
    dec_target = tgt;
    dec_halt   = hlt;
    dec_ready  = 1'b1;
    @(negedge clk);
    cyc++;
    clr_in();
    if (hlt) begin
      chk("halt_st", state, HALT);
      chk("halt_pc", fetch_addr, m_pc);
      chk("halt_ret", retired, m_ret);
      return;
    end
    if (int'(sel) >= N_EU) begin
      chk("bad_st", state, FAULT);
      chk("bad_code", fault_code, 2);
      chk("bad_fault", fault, 1);
      chk("bad_eu_cs", eu_cs, 0);
      return;
    end
    chk("in_exec", state, EXEC);
    chk("eu_cs", eu_cs, oh);
    repeat (ew) begin
      eu_ready = ~oh;
      @(negedge clk);
      cyc++;
      chk("eu_ignore", state, EXEC);
    end
    eu_ready = oh;
    @(negedge clk);
    cyc++;
    eu_ready = '0;
    if (mem) begin
      chk("in_mem", state, MEM);
      chk("biu_cs", biu_cs, 1);
      chk("eu_cs_off", eu_cs, 0);
      biu_ready = 1'b1;
      @(negedge clk);
      cyc++;
      biu_ready = 1'b0;
    end
    chk("in_commit", state, COMMIT);
    chk("biu_cs_off", biu_cs, 0);
    chk("busy", busy, 1);
    m_pc  = br ? tgt : m_pc + 16'd1;
    m_ret = m_ret + 16'd1;
    sb_q.push_back('{pc: m_pc, ret: m_ret,
                     st: halt_req ? HALT : FETCH});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_pc  = '0;
    m_ret = '0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int cyc;
  int tot;

  initial begin
    clr_in();
    start    = 1'b0;
    halt_req = 1'b0;
    reset    = 1'b0;
    m_pc     = '0;
    m_ret    = '0;
    @(negedge clk);
    do_reset();
    chk("rst_state", state, IDLE);
    chk("rst_pc", fetch_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ret", retired, 0);
    chk("rst_cs", {fetch_cs, dec_cs, eu_cs, biu_cs}, 0);
    chk("rst_fault", {fault, fault_code}, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    chk("idle_hold", state, IDLE);

    // Straight-line run.
    kick();
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      do_instr(0, 0, 2'(i), 0, 0, 0, 16'h0, cyc);
      chk("lat4", cyc, 4);
      tot += cyc;
    end
    chk("straight12", tot, 12);
    chk("ret3", retired, 3);

    // Memory plus branch, then PC wrap.
    do_instr(0, 0, 2'd1, 1, 1, 0, 16'h0040, cyc);
    chk("lat5", cyc, 5);
    do_instr(0, 0, 2'd2, 0, 1, 0, 16'hFFFF, cyc);
    do_instr(0, 0, 2'd0, 0, 0, 0, 16'h0, cyc);
    chk("wrap", fetch_addr, 0);

    // Fetch ready on the last allowed waiting cycle.
    do_instr(TMO - 1, 0, 2'd1, 0, 1, 0, 16'h0005, cyc);
    chk("tmo_lat", cyc, 4 + TMO - 1);
    chk("tmo_nofault", fault, 0);

    // HALT instruction at PC=5, then restart.
    do_instr(0, 0, 2'd0, 0, 0, 1, 16'h0, cyc);
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_req_idle", state, HALT);
    halt_req = 1'b0;
    kick();
    chk("restart_st", state, FETCH);
    chk("restart_pc", fetch_addr, 5);

    // halt_req during EXEC: commit completes, then HALT.
    halt_req = 1'b1;
    do_instr(0, 2, 2'd2, 0, 0, 0, 16'h0, cyc);
    halt_req = 1'b0;
    chk("hreq_busy", busy, 0);
    chk("hreq_ret", retired, m_ret);
    kick();

    // Bad EU select is terminal.
    do_instr(0, 0, 2'd3, 0, 0, 0, 16'h0, cyc);
    start       = 1'b1;
    fetch_ready = 1'b1;
    eu_ready    = '1;
    repeat (3) begin
      @(negedge clk);
      chk("flt_hold", state, FAULT);
      chk("flt_eu_cs", eu_cs, 0);
      chk("flt_code", fault_code, 2);
    end
    clr_in();
    start = 1'b0;
    do_reset();
    chk("flt_rst", {state, fault, fault_code}, 0);

    // Reset in the middle of an EXEC handshake.
    kick();
    do_instr(0, 0, 2'd0, 0, 0, 0, 16'h0, cyc);
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    dec_eu_sel  = 2'd1;
    dec_ready   = 1'b1;
    @(negedge clk);
    clr_in();
    chk("mid_exec", state, EXEC);
    chk("mid_eu_cs", eu_cs, 3'b010);
    do_reset();
    chk("mid_state", state, IDLE);
    chk("mid_eu_off", eu_cs, 0);
    chk("mid_pc", fetch_addr, 0);
    chk("mid_ret", retired, 0);
    chk("mid_fault", fault, 0);

    // Fetch never ready: timeout fault.
    kick();
    repeat (TMO - 1) @(negedge clk);
    chk("to_edge", state, FETCH);
    @(negedge clk);
    chk("to_state", state, FAULT);
    chk("to_code", fault_code, 1);
    chk("to_cs", fetch_cs, 0);
    chk("to_fault", fault, 1);
    start       = 1'b1;
    fetch_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_hold", {state, fault_code}, {FAULT, 2'd1});
    start = 1'b0;
    clr_in();
    do_reset();
    chk("to_rst", {state, fault}, 0);

    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised instruction sequencer for the Prathama microprocessor. It replaces the fixed fetch/decode/execute hand-off between the control units with one Moore FSM. It drives chip-select/ready handshakes to the fetch unit, the decoder, N execution units and the bus interface unit, and it owns the program counter. Compared with the previous control path, it adds a configurable EU count, branch redirection, a halt/restart path, per-handshake timeout with fault reporting, and a retired-instruction counter.

## Interface
- IR_W, 32, instruction register width
- ADDR_W, 16, program counter / fetch address width
- N_EU, 2, number of execution units (1..8)
- PC_STEP, 1, PC increment per retired non-branch instruction
- TIMEOUT, 15, max cycles any handshake waits for ready (≥2)
- CNT_W, 16, retired-instruction counter width
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin fetching at current PC
- halt_req  in  1  stop after the instruction in flight commits
- fetch_cs  out  1  fetch request
- fetch_ready  in  1  fetch done, fetch_ir valid
- fetch_ir  in  IR_W  fetched instruction
- fetch_addr  out  ADDR_W  current PC
- ir  out  IR_W  latched instruction
- dec_cs  out  1  decode request
- dec_ready  in  1  decode done, dec_* fields valid
- dec_eu_sel  in  $clog2(N_EU) (min 1)  target EU index
- dec_mem  in  1  instruction needs a BIU transfer after execute
- dec_branch  in  1  branch taken
- dec_target  in  ADDR_W  branch target
- dec_halt  in  1  instruction is HALT
- eu_cs  out  N_EU  one-hot execute request
- eu_ready  in  N_EU  per-EU done
- biu_cs  out  1  memory transfer request
- biu_ready  in  1  transfer done
- state  out  3  FSM state code
- busy  out  1  state is not IDLE, HALT or FAULT
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 timeout, 2 bad EU select
- retired  out  CNT_W  retired-instruction count

## Operation
- States and codes: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, COMMIT 5, HALT 6, FAULT 7.
- Outputs are decoded from the state register only (Moore):
  - fetch_cs=1 in FETCH; dec_cs=1 in DECODE.
  - eu_cs[sel_q]=1 in EXEC; biu_cs=1 in MEM.
- **IDLE**: start → FETCH.
- **FETCH**: fetch_ready → ir←fetch_ir, go DECODE.
- **DECODE**: dec_ready → latch sel_q, mem_q, br_q, tgt_q.
  - If dec_halt: go HALT; PC unchanged, retired unchanged.
  - Else if dec_eu_sel ≥ N_EU: go FAULT with code 2.
  - Else go EXEC.
- **EXEC**: eu_ready[sel_q] → MEM if mem_q, else COMMIT.
  - eu_ready from other EUs is ignored.
- **MEM**: biu_ready → COMMIT.
- **COMMIT** (always exactly 1 cycle):
  - PC update: PC←tgt_q if br_q, else PC+PC_STEP, modulo 2^ADDR_W.
  - retired+1, wrapping at 2^CNT_W.
  - Next state: HALT if halt_req is high this cycle, else FETCH.
- **HALT**: start → FETCH from current PC. halt_req has no effect.
- **FAULT**: terminal; only reset exits. fault=1 and fault_code are held.
- Ready inputs are ignored in every state that is not waiting for them.

## Timing
- Reset (reset=0 at a rising edge) forces these values, from any state including mid-handshake:
  - state=IDLE, PC=0, ir=0, retired=0.
  - All cs outputs 0, fault=0, fault_code=0.
- Handshake: cs is high from the first cycle of the state. Ready is sampled at each rising edge in that state; the transition happens at the edge where ready=1. cs falls in the following cycle.
- Wait counter clears on every state entry and increments each waiting cycle without ready. If ready is still low at the edge ending the TIMEOUT-th waiting cycle, go FAULT with code 1. Ready on that same edge wins over the timeout.
- Minimum latency with ready in the first cycle of every wait state:
  - 4 cycles per non-memory instruction (FETCH, DECODE, EXEC, COMMIT).
  - 5 cycles per memory instruction.
- fetch_addr changes only at the COMMIT edge or on reset; it is stable throughout FETCH.
- start and halt_req are level-sampled only in the states listed above; they have no effect elsewhere.

## Test plan
- **Reset mid-operation**: reset=0 during EXEC with eu_cs=2'b10 → next cycle state=0, eu_cs=0, PC=0, retired=0, fault=0.
- **Straight-line run**: start, 3 instructions, all readies immediate, dec_mem=0 → retired=3 after 12 cycles; fetch_addr goes 0, 1, 2, 3.
- **Memory and branch**: instruction with dec_mem=1, dec_branch=1, dec_target=16'h0040 → biu_cs high for 1 cycle, cycle count 5, next fetch_addr=16'h0040. With PC=16'hFFFF and no branch → next fetch_addr=0.
- **Timeout boundary** (TIMEOUT=15):
  - fetch_ready rises on the 15th waiting cycle → DECODE, no fault.
  - fetch_ready never rises → FAULT, fault_code=1, fetch_cs=0 afterwards.
  - FAULT holds until reset.
- **Bad EU select**: N_EU=3, dec_eu_sel=3 → FAULT, fault_code=2, eu_cs never asserted.
- **Halt paths**:
  - dec_halt=1 at PC=5 → HALT, PC=5, retired unchanged; start → fetch_addr=5.
  - halt_req held during EXEC → COMMIT completes (retired+1), then HALT.
